// File: rtl/multi_rate_counter_pkg.sv
// multi_rate_counter_pkg -- shared rate defaults, hex glyph table and digit-count helper. Rev 1.0
`default_nettype none

package multi_rate_counter_pkg;

   localparam int unsigned DEF_RATE0 = 1;
   localparam int unsigned DEF_RATE1 = 50_000_000;
   localparam int unsigned DEF_RATE2 = 100_000_000;
   localparam int unsigned DEF_RATE3 = 200_000_000;

   // Active-low segments, bit order g..a = 6..0
   localparam logic [6:0] HEX_GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic int ndig(input int w);
      return (w + 3) / 4;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder -- one nibble to an active-low seven-segment glyph. Rev 1.0
`default_nettype none

module hex_seg_decoder
   import multi_rate_counter_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_GLYPH[nibble];

endmodule

`default_nettype wire

// File: rtl/multi_rate_counter.sv
// multi_rate_counter -- up/down wrap/saturate counter stepped at a selectable rate, with hex display. Rev 1.0
`default_nettype none

module multi_rate_counter
   import multi_rate_counter_pkg::*;
#(
   parameter int          CNT_W = 4,
   parameter int          DIV_W = 28,
   parameter int unsigned RATE0 = DEF_RATE0,
   parameter int unsigned RATE1 = DEF_RATE1,
   parameter int unsigned RATE2 = DEF_RATE2,
   parameter int unsigned RATE3 = DEF_RATE3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  sel,
   input  logic                        en,
   input  logic                        dir,
   input  logic                        sat,
   input  logic                        load,
   input  logic [CNT_W-1:0]            load_val,
   output logic [CNT_W-1:0]            count,
   output logic                        tick,
   output logic                        tc,
   output logic [7*ndig(CNT_W)-1:0]    hex
);

   localparam int NDIG = ndig(CNT_W);

   logic [DIV_W-1:0]  div;
   logic [DIV_W-1:0]  reload_val;
   logic [1:0]        sel_q;
   logic              step;
   logic              at_bound;
   logic [4*NDIG-1:0] cnt_pad;

   always_comb begin
      reload_val = DIV_W'(RATE0 - 1);
      case (sel)
         2'd0:    reload_val = DIV_W'(RATE0 - 1);
         2'd1:    reload_val = DIV_W'(RATE1 - 1);
         2'd2:    reload_val = DIV_W'(RATE2 - 1);
         default: reload_val = DIV_W'(RATE3 - 1);
      endcase
   end

   assign step     = en && (div == '0) && !load && (sel == sel_q);
   assign at_bound = dir ? (count == '0) : (&count);

   always_ff @(posedge clk) begin
      sel_q <= sel;
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
         tc    <= 1'b0;
         div   <= reload_val;
      end else if (load) begin
         count <= load_val;
         tick  <= 1'b0;
         tc    <= 1'b0;
         div   <= reload_val;
      end else if (sel != sel_q) begin
         // A rate change restarts the period rather than carrying stale progress
         tick  <= 1'b0;
         tc    <= 1'b0;
         div   <= reload_val;
      end else if (step) begin
         tick  <= 1'b1;
         tc    <= at_bound;
         div   <= reload_val;
         if (!(at_bound && sat)) begin
            count <= dir ? (count - CNT_W'(1)) : (count + CNT_W'(1));
         end
      end else begin
         tick  <= 1'b0;
         tc    <= 1'b0;
         if (en) begin
            div <= div - DIV_W'(1);
         end
      end
   end

   always_comb begin
      cnt_pad            = '0;
      cnt_pad[CNT_W-1:0] = count;
   end

   generate
      for (genvar i = 0; i < NDIG; i++) begin : g_digit
         hex_seg_decoder u_dec (
            .nibble (cnt_pad[4*i +: 4]),
            .seg    (hex[7*i +: 7])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_rate_counter.sv
// tb_multi_rate_counter -- directed self-checking bench, CNT_W=4, rates 1/3/5/8. Rev 1.0
`default_nettype none

module tb_multi_rate_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] sel = 2'd1;
   logic       en = 1'b1;
   logic       dir = 1'b0;
   logic       sat = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] count;
   logic       tick;
   logic       tc;
   logic [6:0] hex;

   int checks = 0;
   int errors = 0;

   multi_rate_counter #(
      .CNT_W (4),
      .DIV_W (8),
      .RATE0 (1),
      .RATE1 (3),
      .RATE2 (5),
      .RATE3 (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sel      (sel),
      .en       (en),
      .dir      (dir),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tick     (tick),
      .tc       (tc),
      .hex      (hex)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string name, input logic [3:0] exp_cnt,
                              input logic exp_tick, input logic exp_tc);
      checks++;
      if (count !== exp_cnt || tick !== exp_tick || tc !== exp_tc) begin
         errors++;
         $display("FAIL %s: count=%0d tick=%b tc=%b, expected count=%0d tick=%b tc=%b",
                  name, count, tick, tc, exp_cnt, exp_tick, exp_tc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; sel = 2'd1; en = 1'b1; dir = 1'b0; sat = 1'b0; load = 1'b0;
      cycle();
      check_state("reset", 4'd0, 1'b0, 1'b0);
      checks++;
      if (hex !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_hex: hex=%b expected %b", hex, 7'b1000000);
      end
   endtask

   task automatic test_count_up();
      // Post-reset sample followed by 11 more edges at rate 3
      logic [3:0] exp_cnt [12] = '{0,0,0,1,1,1,2,2,2,3,3,3};
      logic       exp_tk  [12] = '{0,0,0,1,0,0,1,0,0,1,0,0};
      reset = 1'b0;
      for (int i = 1; i < 12; i++) begin
         cycle();
         check_state($sformatf("count_up[%0d]", i), exp_cnt[i], exp_tk[i], 1'b0);
      end
   endtask

   task automatic test_wrap();
      load_val = 4'd15; load = 1'b1;
      cycle();
      load = 1'b0;
      check_state("wrap_load", 4'd15, 1'b0, 1'b0);
      checks++;
      if (hex !== 7'b0001110) begin
         errors++;
         $display("FAIL wrap_hex_f: hex=%b expected %b", hex, 7'b0001110);
      end
      cycle();
      check_state("wrap_wait1", 4'd15, 1'b0, 1'b0);
      cycle();
      check_state("wrap_wait2", 4'd15, 1'b0, 1'b0);
      cycle();
      check_state("wrap_step", 4'd0, 1'b1, 1'b1);
      checks++;
      if (hex !== 7'b1000000) begin
         errors++;
         $display("FAIL wrap_hex_0: hex=%b expected %b", hex, 7'b1000000);
      end
   endtask

   task automatic test_sat_down();
      load_val = 4'd0; dir = 1'b1; sat = 1'b1; sel = 2'd0; load = 1'b1;
      cycle();
      load = 1'b0;
      check_state("sat_load", 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_state($sformatf("sat_hold[%0d]", i), 4'd0, 1'b1, 1'b1);
      end
   endtask

   task automatic test_sel_change();
      dir = 1'b0; sat = 1'b0; sel = 2'd3;
      cycle();
      check_state("sel3_change", 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      check_state("sel3_run", 4'd0, 1'b0, 1'b0);
      sel = 2'd2;
      cycle();
      check_state("sel2_change", 4'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         cycle();
         if (i < 5) check_state($sformatf("sel2_wait[%0d]", i), 4'd0, 1'b0, 1'b0);
         else       check_state("sel2_step", 4'd1, 1'b1, 1'b0);
      end
   endtask

   task automatic test_en_freeze();
      cycle();
      cycle();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check_state($sformatf("frozen[%0d]", i), 4'd1, 1'b0, 1'b0);
      end
      en = 1'b1;
      cycle();
      check_state("resume1", 4'd1, 1'b0, 1'b0);
      cycle();
      check_state("resume2", 4'd1, 1'b0, 1'b0);
      cycle();
      check_state("resume_step", 4'd2, 1'b1, 1'b0);
   endtask

   task automatic test_hex();
      logic [3:0] vals  [4] = '{4'h5, 4'h9, 4'hA, 4'hb};
      logic [6:0] glyph [4] = '{7'b0010010, 7'b0010000, 7'b0001000, 7'b0000011};
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load_val = vals[i]; load = 1'b1;
         cycle();
         checks++;
         if (count !== vals[i] || hex !== glyph[i]) begin
            errors++;
            $display("FAIL hex[%0d]: count=%h hex=%b expected count=%h hex=%b",
                     i, count, hex, vals[i], glyph[i]);
         end
      end
      load = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_reset_load();
      load_val = 4'd9; load = 1'b1;
      cycle();
      check_state("pre_reset_load", 4'd9, 1'b0, 1'b0);
      reset = 1'b1;
      cycle();
      check_state("reset_over_load", 4'd0, 1'b0, 1'b0);
      reset = 1'b0; load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap();
      test_sat_down();
      test_sel_change();
      test_en_freeze();
      test_hex();
      test_reset_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
